// File: rtl/mic_pkg.sv
// ---------------------------------------------------------------------------
// mic_pkg
// Shared definitions for the microphone beamforming datapath: PCM sample
// width and type (also used by the delay line and summer), CIC order, the
// decimator state encoding and a helper that sizes the CIC accumulators.
// ---------------------------------------------------------------------------
package mic_pkg;

    localparam int PCM_W     = 19;
    localparam int CIC_ORDER = 3;

    typedef logic signed [PCM_W-1:0] pcm_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WARMUP = 2'd1,
        RUN    = 2'd2
    } cic_state_e;

    // Accumulator width for a CIC of order CIC_ORDER and ratio decim.
    function automatic int acc_width(input int decim);
        return 1 + CIC_ORDER * $clog2(decim);
    endfunction

endpackage

// File: rtl/pdm_clk_gen.sv
// ---------------------------------------------------------------------------
// pdm_clk_gen
// Divides clk_i down to the microphone PDM clock and produces a one-clk
// sample strobe in the last clk of each pdm_clk high phase.
//
// Ports:
//   clk_i      system clock
//   rst_ni     asynchronous active-low reset
//   run_i      1 = divider runs, 0 = counter cleared and pdm_clk_o held low
//   pdm_clk_o  clock to the microphone, period 2*CLK_DIV clk_i
//   strobe_o   sample strobe (divider wrap while pdm_clk_o is high)
// ---------------------------------------------------------------------------
module pdm_clk_gen #(
    parameter int CLK_DIV = 25
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic run_i,
    output logic pdm_clk_o,
    output logic strobe_o
);

    localparam int CNT_W = $clog2(CLK_DIV);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pclk_q, pclk_d;
    logic             wrap_w;

    assign wrap_w = (cnt_q == CNT_W'(CLK_DIV - 1));

    always_comb begin
        cnt_d  = cnt_q;
        pclk_d = pclk_q;
        if (!run_i) begin
            cnt_d  = '0;
            pclk_d = 1'b0;
        end else if (wrap_w) begin
            cnt_d  = '0;
            pclk_d = ~pclk_q;
        end else begin
            cnt_d  = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q  <= '0;
            pclk_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            pclk_q <= pclk_d;
        end
    end

    assign pdm_clk_o = pclk_q;
    // The falling edge follows this clk, so the mic data is mid-window here.
    assign strobe_o  = run_i & wrap_w & pclk_q;

endmodule

// File: rtl/pdm_cic_decimator.sv
// ---------------------------------------------------------------------------
// pdm_cic_decimator
// Generates the PDM clock for one MEMS microphone, captures its 1-bit
// stream and decimates it to signed 19-bit PCM with a 3rd-order CIC.
//
// Ports:
//   clk        system clock
//   rst_n      asynchronous active-low reset
//   en         run enable; low clears the datapath and idles the block
//   pdm_clk    clock to the microphone
//   pdm_data   PDM bit from the microphone (asynchronous to clk)
//   pcm_data   signed PCM sample
//   pcm_valid  one-clk strobe, pcm_data is new
//   pcm_clip   high with pcm_valid when the sample was limited
//
// Build option: define PDM_CIC_SAT_EN to saturate the output to the 19-bit
// range and report it on pcm_clip; otherwise the low 19 bits are passed
// through and pcm_clip stays 0.
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | en low; divider, integrators, combs and counters cleared
// WARMUP | running, first CIC_ORDER decimated outputs discarded
// RUN    | running, every decimated output pulses pcm_valid
// ---------------------------------------------------------------------------
module pdm_cic_decimator
    import mic_pkg::*;
#(
    parameter int CLK_DIV = 25,
    parameter int DECIM   = 64
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    output logic                    pdm_clk,
    input  logic                    pdm_data,
    output logic signed [PCM_W-1:0] pcm_data,
    output logic                    pcm_valid,
    output logic                    pcm_clip
);

    localparam int ACC_W = acc_width(DECIM);
    // One guard bit so that full-scale +DECIM^3 and -DECIM^3 stay distinct
    // after the comb; without it saturation could not see the overflow.
    localparam int CIC_W = ACC_W + 1;
    localparam int DEC_W = $clog2(DECIM);
    localparam int SHIFT = PCM_W - ACC_W;
    localparam int EXT_W = PCM_W + 1;

    typedef logic signed [CIC_W-1:0] cic_t;

    // ------------------------------------------------------------------
    // Clock divider and sample strobe
    // ------------------------------------------------------------------
    logic strobe_w;

    pdm_clk_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_clk_gen (
        .clk_i     (clk),
        .rst_ni    (rst_n),
        .run_i     (en),
        .pdm_clk_o (pdm_clk),
        .strobe_o  (strobe_w)
    );

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    cic_state_e       state_q, state_d;
    logic [1:0]       sync_q, sync_d;
    cic_t             i1_q, i1_d, i2_q, i2_d, i3_q, i3_d;
    cic_t             dly1_q, dly1_d, dly2_q, dly2_d, dly3_q, dly3_d;
    cic_t             comb_q, comb_d;
    logic             comb_vld_q, comb_vld_d;
    logic [DEC_W-1:0] dec_q, dec_d;
    logic [1:0]       warm_q, warm_d;
    pcm_t             pcm_data_q, pcm_data_d;
    logic             pcm_valid_q, pcm_valid_d;
    logic             pcm_clip_q, pcm_clip_d;

    logic             frame_end_w;
    logic             emit_w;
    logic             warm_adv_w;
    cic_t             x_w, i3_post_w, c1_w, c2_w, c3_w;
    pcm_t             sat_w;
    logic             clip_w;

    assign frame_end_w = strobe_w & (dec_q == DEC_W'(DECIM - 1));

    // ------------------------------------------------------------------
    // FSM: state register / next state / outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (!en) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    state_d = WARMUP;
                WARMUP:  if (frame_end_w && warm_q == 2'(CIC_ORDER - 1)) state_d = RUN;
                RUN:     state_d = RUN;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        emit_w     = (state_q == RUN);
        warm_adv_w = (state_q == WARMUP) & frame_end_w;
    end

    // ------------------------------------------------------------------
    // CIC datapath
    // ------------------------------------------------------------------
    assign x_w       = sync_q[1] ? cic_t'(1) : '1;
    // I3 after this strobe's update; the comb consumes it in the same clk.
    assign i3_post_w = i3_q + i2_q;
    assign c1_w      = i3_post_w - dly1_q;
    assign c2_w      = c1_w - dly2_q;
    assign c3_w      = c2_w - dly3_q;

`ifdef PDM_CIC_SAT_EN
    localparam logic signed [EXT_W-1:0] EXT_MAX = EXT_W'((1 <<< (PCM_W - 1)) - 1);
    localparam logic signed [EXT_W-1:0] EXT_MIN = ~EXT_MAX;

    logic signed [EXT_W-1:0] ext_w, scaled_w;

    always_comb begin
        ext_w    = EXT_W'(comb_q);
        scaled_w = ext_w <<< SHIFT;
        clip_w   = 1'b0;
        sat_w    = scaled_w[PCM_W-1:0];
        if (scaled_w > EXT_MAX) begin
            sat_w  = EXT_MAX[PCM_W-1:0];
            clip_w = 1'b1;
        end else if (scaled_w < EXT_MIN) begin
            sat_w  = EXT_MIN[PCM_W-1:0];
            clip_w = 1'b1;
        end
    end
`else
    pcm_t comb_pcm_w;

    always_comb begin
        comb_pcm_w = PCM_W'(comb_q);
        sat_w      = comb_pcm_w <<< SHIFT;
        clip_w     = 1'b0;
    end
`endif

    always_comb begin
        sync_d      = {sync_q[0], pdm_data};
        i1_d        = i1_q;
        i2_d        = i2_q;
        i3_d        = i3_q;
        dly1_d      = dly1_q;
        dly2_d      = dly2_q;
        dly3_d      = dly3_q;
        comb_d      = comb_q;
        comb_vld_d  = 1'b0;
        dec_d       = dec_q;
        warm_d      = warm_q;
        pcm_data_d  = comb_vld_q ? sat_w : pcm_data_q;
        pcm_valid_d = comb_vld_q;
        pcm_clip_d  = comb_vld_q & clip_w;

        if (!en) begin
            // Partial frame is dropped; pcm_data keeps its last value.
            i1_d        = '0;
            i2_d        = '0;
            i3_d        = '0;
            dly1_d      = '0;
            dly2_d      = '0;
            dly3_d      = '0;
            comb_d      = '0;
            dec_d       = '0;
            warm_d      = '0;
            pcm_data_d  = pcm_data_q;
            pcm_valid_d = 1'b0;
            pcm_clip_d  = 1'b0;
        end else begin
            if (strobe_w) begin
                i1_d  = i1_q + x_w;
                i2_d  = i2_q + i1_q;
                i3_d  = i3_post_w;
                dec_d = frame_end_w ? '0 : dec_q + DEC_W'(1);
            end
            if (frame_end_w) begin
                dly1_d     = i3_post_w;
                dly2_d     = c1_w;
                dly3_d     = c2_w;
                comb_d     = c3_w;
                comb_vld_d = emit_w;
            end
            if (warm_adv_w) begin
                warm_d = warm_q + 2'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q      <= '0;
            i1_q        <= '0;
            i2_q        <= '0;
            i3_q        <= '0;
            dly1_q      <= '0;
            dly2_q      <= '0;
            dly3_q      <= '0;
            comb_q      <= '0;
            comb_vld_q  <= 1'b0;
            dec_q       <= '0;
            warm_q      <= '0;
            pcm_data_q  <= '0;
            pcm_valid_q <= 1'b0;
            pcm_clip_q  <= 1'b0;
        end else begin
            sync_q      <= sync_d;
            i1_q        <= i1_d;
            i2_q        <= i2_d;
            i3_q        <= i3_d;
            dly1_q      <= dly1_d;
            dly2_q      <= dly2_d;
            dly3_q      <= dly3_d;
            comb_q      <= comb_d;
            comb_vld_q  <= comb_vld_d;
            dec_q       <= dec_d;
            warm_q      <= warm_d;
            pcm_data_q  <= pcm_data_d;
            pcm_valid_q <= pcm_valid_d;
            pcm_clip_q  <= pcm_clip_d;
        end
    end

    assign pcm_data  = pcm_data_q;
    assign pcm_valid = pcm_valid_q;
    assign pcm_clip  = pcm_clip_q;

endmodule

// File: tb/tb_pdm_cic_decimator.sv
// ---------------------------------------------------------------------------
// tb_pdm_cic_decimator
// Directed bench for pdm_cic_decimator with default parameters. Expected
// PCM samples (value, clip flag and arrival clk) are queued when a run is
// started and checked by a monitor whenever pcm_valid is seen.
// Build with or without PDM_CIC_SAT_EN to match the RTL configuration.
// ---------------------------------------------------------------------------
module tb_pdm_cic_decimator;
    import mic_pkg::*;

    localparam int CLK_DIV = 25;
    localparam int DECIM   = 64;
    localparam int FRAME   = DECIM * 2 * CLK_DIV;

`ifdef PDM_CIC_SAT_EN
    localparam logic signed [31:0] EXP_ONE      = 262143;
    localparam logic               EXP_ONE_CLIP = 1'b1;
`else
    localparam logic signed [31:0] EXP_ONE      = -262144;
    localparam logic               EXP_ONE_CLIP = 1'b0;
`endif
    localparam logic signed [31:0] EXP_ZERO = -262144;

    logic                    clk      = 1'b0;
    logic                    rst_n    = 1'b0;
    logic                    en       = 1'b0;
    logic                    pdm_data = 1'b0;
    logic                    pdm_clk;
    logic signed [PCM_W-1:0] pcm_data;
    logic                    pcm_valid;
    logic                    pcm_clip;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    int en_cyc = 0;

    typedef struct {
        int                 cyc;
        logic signed [31:0] data;
        logic               clip;
    } exp_t;

    exp_t sb[$];

    pdm_cic_decimator #(
        .CLK_DIV (CLK_DIV),
        .DECIM   (DECIM)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .pdm_clk   (pdm_clk),
        .pdm_data  (pdm_data),
        .pcm_data  (pcm_data),
        .pcm_valid (pcm_valid),
        .pcm_clip  (pcm_clip)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic signed [31:0] obs,
                         input logic signed [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Scoreboard consumer.
    always @(negedge clk) begin
        exp_t e;
        if (pcm_valid !== 1'b0) begin
            checks++;
            assert (sb.size() > 0)
            else begin
                errors++;
                $error("FAIL unexpected_valid: observed valid at clk %0d expected none", cyc - en_cyc);
            end
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("valid_time", cyc, e.cyc);
                check("pcm_data", pcm_data, e.data);
                check("pcm_clip", pcm_clip, e.clip);
            end
        end
    end

    task automatic push_frames(input int first, input int n,
                               input logic signed [31:0] d, input logic c);
        exp_t e;
        for (int k = first; k < first + n; k++) begin
            e.cyc  = en_cyc + k * FRAME + 1;
            e.data = d;
            e.clip = c;
            sb.push_back(e);
        end
    endtask

    // Raise en and queue the samples expected from frame 4 on.
    task automatic start(input bit measure, input int nfr,
                         input logic signed [31:0] d, input logic c);
        int   rise1, fall1, rise2, stb1;
        logic prev, stb_pclk;
        @(posedge clk);
        #1;
        en_cyc = cyc;
        en     = 1'b1;
        push_frames(CIC_ORDER + 1, nfr, d, c);
        if (measure) begin
            rise1 = -1; fall1 = -1; rise2 = -1; stb1 = -1;
            prev = 1'b0; stb_pclk = 1'b0;
            repeat (80) begin
                @(negedge clk);
                if (pdm_clk === 1'b1 && prev === 1'b0) begin
                    if (rise1 < 0) rise1 = cyc - en_cyc;
                    else if (rise2 < 0) rise2 = cyc - en_cyc;
                end
                if (pdm_clk === 1'b0 && prev === 1'b1 && fall1 < 0) fall1 = cyc - en_cyc;
                if (dut.u_clk_gen.strobe_o === 1'b1 && stb1 < 0) begin
                    stb1     = cyc - en_cyc;
                    stb_pclk = pdm_clk;
                end
                prev = pdm_clk;
            end
            check("pdm_clk_first_rise", rise1, CLK_DIV);
            check("pdm_clk_high_end", fall1, 2 * CLK_DIV);
            check("pdm_clk_period", rise2 - rise1, 2 * CLK_DIV);
            check("strobe_time", stb1, 2 * CLK_DIV - 1);
            check("strobe_pdm_clk_high", stb_pclk, 1);
        end
    endtask

    task automatic wait_until(input int target, input bit alt);
        logic prev;
        prev = pdm_clk;
        while (cyc < target) begin
            @(negedge clk);
            if (alt && pdm_clk === 1'b1 && prev === 1'b0) pdm_data = ~pdm_data;
            prev = pdm_clk;
        end
    endtask

    task automatic stop_en();
        @(posedge clk);
        #1;
        en = 1'b0;
    endtask

    initial begin
        int pclk_high;

        // Reset values
        #23;
        check("rst_pdm_clk", pdm_clk, 0);
        check("rst_pcm_data", pcm_data, 0);
        check("rst_pcm_valid", pcm_valid, 0);
        check("rst_pcm_clip", pcm_clip, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);

        // Constant 1: divider timing, warm-up, full-scale result
        pdm_data = 1'b1;
        start(1'b1, 1, EXP_ONE, EXP_ONE_CLIP);
        wait_until(en_cyc + (CIC_ORDER + 1) * FRAME + 1500, 1'b0);
        check("const1_drained", sb.size(), 0);

        // en dropped mid-frame, idle for 100 clk
        stop_en();
        @(posedge clk);
        pclk_high = 0;
        repeat (100) begin
            @(negedge clk);
            if (pdm_clk !== 1'b0) pclk_high++;
        end
        check("idle_pdm_clk_low", pclk_high, 0);
        check("idle_pcm_data_held", pcm_data, EXP_ONE);

        // Re-raise with constant 0: three fresh warm-up frames again
        pdm_data = 1'b0;
        start(1'b0, 2, EXP_ZERO, 1'b0);
        wait_until(en_cyc + (CIC_ORDER + 2) * FRAME + 1000, 1'b0);
        check("const0_drained", sb.size(), 0);

        // Reset mid-frame
        #3;
        rst_n = 1'b0;
        #1;
        check("midrst_pcm_data", pcm_data, 0);
        check("midrst_pcm_valid", pcm_valid, 0);
        check("midrst_pcm_clip", pcm_clip, 0);
        check("midrst_pdm_clk", pdm_clk, 0);
        en = 1'b0;
        #20;
        rst_n = 1'b1;
        repeat (3) @(posedge clk);

        // Constant 1 after reset: same value and timing as the first run
        pdm_data = 1'b1;
        start(1'b0, 1, EXP_ONE, EXP_ONE_CLIP);
        wait_until(en_cyc + (CIC_ORDER + 1) * FRAME + 20, 1'b0);
        check("const1_again_drained", sb.size(), 0);

        // Alternating 1,0 per PDM sample: steady zero, one sample per frame
        stop_en();
        repeat (5) @(posedge clk);
        pdm_data = 1'b0;
        start(1'b0, 3, 0, 1'b0);
        wait_until(en_cyc + (CIC_ORDER + 3) * FRAME + 20, 1'b1);
        check("alt_drained", sb.size(), 0);

        stop_en();
        repeat (10) @(posedge clk);
        check("final_queue_empty", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #(FRAME * 30 * 10);
        checks++;
        errors++;
        $display("FAIL watchdog: observed timeout at clk %0d expected completion", cyc);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
